// File: rtl/maxpool_ctrl.sv
// 2x2 max-pooling sequencer: reads each window from RAM, writes its maximum.
// Define MAXPOOL_SIGNED_EN to compare pixels as signed 8-bit values.
module maxpool_ctrl #(
    parameter int unsigned IMG_W    = 4,
    parameter int unsigned IMG_H    = 4,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic [31:0] LAST_COL = 32'(IMG_W / 2 - 1);
    localparam logic [31:0] LAST_ROW = 32'(IMG_H / 2 - 1);

    logic [2:0]  state;
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] out_idx;
    logic [1:0]  k;
    logic [7:0]  mx;
    logic        gt;
    logic [31:0] rd_addr;

`ifdef MAXPOOL_SIGNED_EN
    always_comb gt = $signed(mem_rdata) > $signed(mx);
`else
    always_comb gt = mem_rdata > mx;
`endif

    always_comb begin
        rd_addr = IN_BASE
                + (32'd2 * row + {31'd0, k[1]}) * IMG_W
                + 32'd2 * col + {31'd0, k[0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            col     <= '0;
            k       <= '0;
            out_idx <= '0;
            mx      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_READ;
                        row     <= '0;
                        col     <= '0;
                        k       <= '0;
                        out_idx <= '0;
                    end
                end
                S_READ: begin
                    // read data lags the address by one cycle
                    if (k == 2'd1)
                        mx <= mem_rdata;
                    else if (k != 2'd0 && gt)
                        mx <= mem_rdata;
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        state <= S_LAST;
                end
                S_LAST: begin
                    if (gt)
                        mx <= mem_rdata;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    out_idx <= out_idx + 32'd1;
                    k       <= '0;
                    if (col == LAST_COL) begin
                        col <= '0;
                        row <= row + 32'd1;
                    end else begin
                        col <= col + 32'd1;
                    end
                    if (row == LAST_ROW && col == LAST_COL)
                        state <= S_FIN;
                    else
                        state <= S_READ;
                end
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_READ: begin
                busy     = 1'b1;
                mem_en   = 1'b1;
                mem_addr = rd_addr;
            end
            S_LAST:  busy = 1'b1;
            S_WRITE: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = OUT_BASE + out_idx;
                mem_wdata = mx;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Scoreboard bench for maxpool_ctrl on a 4x4 map with a small RAM model.
// Expected writes are queued at start and popped as the DUT writes.
module tb_maxpool_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  in_ram [0:15];
    logic [39:0] exp_q [$];
    logic [31:0] addr_q [$];

    int npass = 0;
    int ntot = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int first_cyc = 0;
    int done_cyc = 0;
    bit busy_prev = 1'b0;
    bit trace_on = 1'b0;

    maxpool_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en && !mem_we)
            mem_rdata <= in_ram[mem_addr[3:0]];
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        ntot++;
        if (obs === exp)
            npass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pmax(input logic [7:0] a,
                                        input logic [7:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) > $signed(b)) ? a : b;
`else
        return (a > b) ? a : b;
`endif
    endfunction

    always @(negedge clk) begin
        logic [39:0] e;
        if (mem_en && mem_we) begin
            wr_cnt++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", mem_addr, e[39:8]);
                check("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
            end else begin
                check("wr_unexpected", mem_addr, 32'hFFFF_FFFF);
            end
        end else if (mem_wdata != 8'h00) begin
            check("wdata_idle", {24'd0, mem_wdata}, 32'd0);
        end
        if (trace_on && mem_en)
            addr_q.push_back(mem_addr);
        if (busy && !busy_prev)
            first_cyc = cyc;
        busy_prev = busy;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_busy", {31'd0, busy}, 32'd0);
        end
    end

    task automatic push_expected();
        logic [7:0] m;
        int idx;
        idx = 0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                m = in_ram[(2 * r) * 4 + 2 * c];
                m = pmax(m, in_ram[(2 * r) * 4 + 2 * c + 1]);
                m = pmax(m, in_ram[(2 * r + 1) * 4 + 2 * c]);
                m = pmax(m, in_ram[(2 * r + 1) * 4 + 2 * c + 1]);
                exp_q.push_back({32'(1024 + idx), m});
                idx++;
            end
        end
    endtask

    task automatic run_job(input string tag, input int restart_at);
        int n;
        int d0;
        int w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        push_expected();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            if (n == restart_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_writes"}, 32'(wr_cnt - w0), 32'd4);
        check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_len"}, 32'(done_cyc - first_cyc), 32'd24);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int w0;
        int d0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_en", {31'd0, mem_en}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) in_ram[i] = 8'(i);
        run_job("ramp", -1);

        for (int i = 0; i < 16; i++) in_ram[i] = 8'($urandom);
        in_ram[0] = 8'h80;
        in_ram[1] = 8'h7F;
        in_ram[4] = 8'hFF;
        in_ram[5] = 8'h01;
        in_ram[2] = 8'h00;
        in_ram[3] = 8'h00;
        in_ram[6] = 8'h00;
        in_ram[7] = 8'h00;
        run_job("sign", -1);

        for (int i = 0; i < 16; i++) in_ram[i] = 8'($urandom);
        run_job("restart", 10);

        // abandon a job during the second window's third read
        for (int i = 0; i < 16; i++) in_ram[i] = 8'(i);
        push_expected();
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("mid_addr", mem_addr, 32'd6);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("mid_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_writes", 32'(wr_cnt - w0), 32'd1);
        check("mid_done", 32'(done_cnt - d0), 32'd0);
        check("mid_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_job("after_rst", -1);

        for (int i = 0; i < 16; i++) in_ram[i] = 8'h33;
        addr_q.delete();
        trace_on = 1'b1;
        run_job("equal", -1);
        trace_on = 1'b0;
        check("seq_len", 32'(addr_q.size()), 32'd20);
        if (addr_q.size() >= 5) begin
            check("seq0", addr_q[0], 32'd0);
            check("seq1", addr_q[1], 32'd1);
            check("seq2", addr_q[2], 32'd4);
            check("seq3", addr_q[3], 32'd5);
            check("seq4", addr_q[4], 32'd1024);
        end

        for (int i = 0; i < 16; i++)
            in_ram[i] = (i % 3 == 0) ? 8'hFF : 8'h00;
        run_job("extreme", -1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
